// File: rtl/duty_ramp_pkg.sv
// Shared widths, FSM state type and the saturating step arithmetic for duty_ramp.
package duty_ramp_pkg;

  localparam int DUTY_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // One step toward tgt, evaluated at DUTY_W+1 bits so it clamps at the target instead of wrapping.
  function automatic logic [DUTY_W-1:0] step_calc(
    input logic              up,
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W:0]   step
  );
    logic [DUTY_W:0] cur_w;
    logic [DUTY_W:0] tgt_w;
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    if (up) begin
      if (cur_w + step >= tgt_w) step_calc = tgt;
      else                       step_calc = cur + step[DUTY_W-1:0];
    end else begin
      if (cur_w < tgt_w + step)  step_calc = tgt;
      else                       step_calc = cur - step[DUTY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/duty_ramp_step_timer.sv
// Tick counter pacing duty_ramp: step_en fires on the TICKS_PER_STEP-th tick while running.
module step_timer
  import duty_ramp_pkg::*;
#(
  parameter int TICKS_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic tick,
  output logic step_en
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_STEP - 1);

  logic [CNT_W-1:0] cnt;

  assign step_en = run && tick && (cnt == LAST);

  // Count ticks while a ramp runs; wrap to zero on each step.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 16'd0;
    end else if (run && tick) begin
      if (cnt == LAST) cnt <= 16'd0;
      else             cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// Slew-limited duty setpoint generator with one pending target slot.
// Optional emergency stop input enabled by defining DUTY_RAMP_ESTOP_EN.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int STEP           = 1,
  parameter int TICKS_PER_STEP = 4,
  parameter int DUTY_INIT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
`ifdef DUTY_RAMP_ESTOP_EN
  input  logic              estop,
`endif
  input  logic              tgt_valid,
  input  logic [DUTY_W-1:0] tgt_duty,
  output logic              tgt_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  localparam logic [DUTY_W:0]   STEP_V = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);

  state_t            state;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] pend;
  logic              pend_full;
  logic              eq_pend;
  logic              step_en;
  logic              xfer;
  logic              estop_s;
  logic [DUTY_W-1:0] next_duty;
  logic [DUTY_W-1:0] load_val;

`ifdef DUTY_RAMP_ESTOP_EN
  assign estop_s = estop;
`else
  assign estop_s = 1'b0;
`endif

  assign tgt_ready = !pend_full && !estop_s;
  assign xfer      = tgt_valid && tgt_ready;
  assign next_duty = step_calc(state == UP, duty, target, STEP_V);
  // A target captured while finishing a ramp waits in the pending slot and wins over the input.
  assign load_val  = pend_full ? pend : tgt_duty;

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == IDLE) || estop_s),
    .run     (state != IDLE),
    .tick    (tick),
    .step_en (step_en)
  );

  // Ramp FSM: loads targets, applies steps, chains the pending target on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      duty      <= INIT_V;
      target    <= INIT_V;
      pend      <= 8'd0;
      pend_full <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      eq_pend   <= 1'b0;
    end else if (estop_s) begin
      state     <= IDLE;
      duty      <= 8'd0;
      pend_full <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      eq_pend   <= 1'b0;
    end else begin
      done    <= eq_pend;
      eq_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_full || xfer) begin
            target    <= load_val;
            pend_full <= 1'b0;
            if (load_val > duty) begin
              state <= UP;
              busy  <= 1'b1;
            end else if (load_val < duty) begin
              state <= DOWN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        UP, DOWN: begin
          if (xfer) begin
            pend      <= tgt_duty;
            pend_full <= 1'b1;
          end
          if (step_en) begin
            duty <= next_duty;
            if (next_duty == target) begin
              done <= 1'b1;
              if (pend_full) begin
                target    <= pend;
                pend_full <= 1'b0;
                if (pend > next_duty) begin
                  state <= UP;
                  busy  <= 1'b1;
                end else if (pend < next_duty) begin
                  state <= DOWN;
                  busy  <= 1'b1;
                end else begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  eq_pend <= 1'b1;
                end
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: fast instance A checked every cycle against a behavioural model,
// slow instance B checked with hand-computed timing. Covers estop when DUTY_RAMP_ESTOP_EN is defined.
module tb_duty_ramp;

  localparam int A_STEP = 16;
  localparam int A_TPS  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_a = 1'b1, valid_a = 1'b0, ready_a, busy_a, done_a;
  logic [7:0] data_a = 8'd0, duty_a;
  logic       tick_b = 1'b0, valid_b = 1'b0, ready_b, busy_b, done_b;
  logic [7:0] data_b = 8'd0, duty_b;
`ifdef DUTY_RAMP_ESTOP_EN
  logic       estop_a = 1'b0;
  logic       estop_b = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model state: duty, active target, ramp active flag, tick count, done, deferred done, pending queue
  int m_duty = 0, m_tgt = 0, m_act = 0, m_cnt = 0, m_done = 0, m_eq = 0;
  int m_pend[$];

  always #5 clk = ~clk;

  duty_ramp #(.STEP(A_STEP), .TICKS_PER_STEP(A_TPS), .DUTY_INIT(0)) dut_a (
    .clk(clk), .rst(rst), .tick(tick_a),
`ifdef DUTY_RAMP_ESTOP_EN
    .estop(estop_a),
`endif
    .tgt_valid(valid_a), .tgt_duty(data_a), .tgt_ready(ready_a),
    .duty(duty_a), .busy(busy_a), .done(done_a)
  );

  duty_ramp #(.STEP(1), .TICKS_PER_STEP(4), .DUTY_INIT(0)) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b),
`ifdef DUTY_RAMP_ESTOP_EN
    .estop(estop_b),
`endif
    .tgt_valid(valid_b), .tgt_duty(data_b), .tgt_ready(ready_b),
    .duty(duty_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_ready();
    int r;
    r = (m_pend.size() == 0) ? 1 : 0;
`ifdef DUTY_RAMP_ESTOP_EN
    if (estop_a) r = 0;
`endif
    return r;
  endfunction

  // Advance the model using the inputs present before the edge, then step one clock.
  task automatic cyc();
    int nd, nt, na, nc, ndn, neq, xfer, diff, had_pend, stop;
    int np[$];
    nd = m_duty; nt = m_tgt; na = m_act; nc = m_cnt; np = m_pend;
    ndn = m_eq; neq = 0; stop = 0;
    xfer = (valid_a && model_ready() != 0) ? 1 : 0;
`ifdef DUTY_RAMP_ESTOP_EN
    stop = estop_a ? 1 : 0;
`endif
    if (rst || stop != 0) begin
      nd = 0; na = 0; nc = 0; ndn = 0; np.delete();
    end else if (na == 0) begin
      if (np.size() > 0 || xfer != 0) begin
        nt = (np.size() > 0) ? np.pop_front() : int'(data_a);
        if (nt == nd) ndn = 1;
        else begin na = 1; nc = 0; end
      end
    end else begin
      had_pend = (np.size() > 0) ? 1 : 0;
      if (xfer != 0) np.push_back(int'(data_a));
      if (tick_a) begin
        nc++;
        if (nc == A_TPS) begin
          nc = 0;
          diff = nt - nd;
          if (diff > 0) nd += (diff > A_STEP) ? A_STEP : diff;
          else          nd += (-diff > A_STEP) ? -A_STEP : diff;
          if (nd == nt) begin
            ndn = 1;
            if (had_pend != 0) begin
              nt = np.pop_front();
              if (nt == nd) begin na = 0; neq = 1; end
            end else begin
              na = 0;
            end
          end
        end
      end
    end
    @(posedge clk);
    m_duty = nd; m_tgt = nt; m_act = na; m_cnt = nc; m_done = ndn; m_eq = neq; m_pend = np;
    #1;
  endtask

  // Every-cycle comparison of instance A against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_duty", duty_a, m_duty);
      chk("model_busy", busy_a, m_act);
      chk("model_done", done_a, m_done);
      chk("model_ready", ready_a, model_ready());
    end
  end

  initial begin
    int acc, acc_k, dn, first_k, last_k;
    repeat (2) cyc();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_duty", duty_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", ready_a, 1);

    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("idle_done", done_a, 0);
    end
    chk("idle_duty", duty_a, 0);

    // 0 -> 250 in steps of 16, clamped at the end
    valid_a = 1'b1; data_a = 8'd250; cyc(); valid_a = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("up_duty", duty_a, (i < 16) ? 16 * i : 250);
      chk("up_done", done_a, (i == 16) ? 1 : 0);
      chk("up_busy", busy_a, (i < 16) ? 1 : 0);
    end

    // 250 -> 5, clamps without underflow
    valid_a = 1'b1; data_a = 8'd5; cyc(); valid_a = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("down_duty", duty_a, (i < 16) ? 250 - 16 * i : 5);
      chk("down_done", done_a, (i == 16) ? 1 : 0);
    end

    // Ramp to 200 with 100 pending; 50 held off until 200 completes
    valid_a = 1'b1; data_a = 8'd200; cyc();
    data_a = 8'd100; cyc();
    chk("pend_ready_low", ready_a, 0);
    data_a = 8'd50;
    acc_k = -1; dn = 0; first_k = -1; last_k = -1;
    for (int k = 2; k <= 30; k++) begin
      acc = (valid_a && ready_a) ? 1 : 0;
      cyc();
      if (acc != 0) begin valid_a = 1'b0; acc_k = k; end
      if (done_a) begin dn++; if (first_k < 0) first_k = k; last_k = k; end
    end
    chk("pend_accept_edge", acc_k, 14);
    chk("pend_done_count", dn, 3);
    chk("pend_first_done", first_k, 13);
    chk("pend_last_done", last_k, 24);

    // Back to 0, then reset mid-ramp at 96 with a pending target queued
    valid_a = 1'b1; data_a = 8'd0; cyc(); valid_a = 1'b0;
    repeat (6) cyc();
    valid_a = 1'b1; data_a = 8'd250; cyc();
    data_a = 8'd200; cyc(); valid_a = 1'b0;
    repeat (5) cyc();
    chk("pre_rst_duty", duty_a, 96);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_duty", duty_a, 0);
    chk("mid_rst_ready", ready_a, 1);
    repeat (3) cyc();
    chk("mid_rst_pend_dropped", busy_a, 0);

    // Target equal to current duty
    valid_a = 1'b1; data_a = 8'd0; cyc(); valid_a = 1'b0;
    chk("eq_done", done_a, 1);
    chk("eq_busy", busy_a, 0);
    cyc();
    chk("eq_done_once", done_a, 0);

    // Transfer on the same edge as completion with an empty pending slot
    valid_a = 1'b1; data_a = 8'd32; cyc();
    valid_a = 1'b0; cyc();
    valid_a = 1'b1; data_a = 8'd0; cyc(); valid_a = 1'b0;
    chk("same_edge_done", done_a, 1);
    chk("same_edge_ready", ready_a, 0);
    chk("same_edge_idle", busy_a, 0);
    cyc();
    chk("same_edge_load", busy_a, 1);
    repeat (4) cyc();
    chk("same_edge_final", duty_a, 0);

    // Gapped ticks toward 40
    tick_a = 1'b0; valid_a = 1'b1; data_a = 8'd40; cyc(); valid_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick_a = k[0];
      cyc();
    end
    tick_a = 1'b1;
    chk("gap_duty", duty_a, 40);

`ifdef DUTY_RAMP_ESTOP_EN
    valid_a = 1'b1; data_a = 8'd0; cyc(); valid_a = 1'b0;
    repeat (4) cyc();
    valid_a = 1'b1; data_a = 8'd250; cyc();
    data_a = 8'd10; cyc(); valid_a = 1'b0;
    repeat (7) cyc();
    chk("pre_estop_duty", duty_a, 128);
    estop_a = 1'b1; cyc();
    chk("estop_duty", duty_a, 0);
    chk("estop_ready", ready_a, 0);
    chk("estop_busy", busy_a, 0);
    chk("estop_done", done_a, 0);
    repeat (2) cyc();
    chk("estop_ready_hold", ready_a, 0);
    estop_a = 1'b0; cyc();
    chk("estop_release_ready", ready_a, 1);
    chk("estop_release_busy", busy_a, 0);
    chk("estop_release_duty", duty_a, 0);
`endif

    // Instance B: STEP=1, four ticks per step, tick on every third edge, target 3
    valid_b = 1'b1; data_b = 8'd3; tick_b = 1'b0; cyc(); valid_b = 1'b0;
    chk("slow_busy_start", busy_b, 1);
    for (int k = 1; k <= 40; k++) begin
      tick_b = (k % 3 == 0) ? 1'b1 : 1'b0;
      cyc();
      chk("slow_duty", duty_b, (k >= 36) ? 3 : k / 12);
      chk("slow_done", done_b, (k == 36) ? 1 : 0);
      chk("slow_busy", busy_b, (k < 36) ? 1 : 0);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_ramp.md
Name: duty_ramp

Overview:
- Slew-rate-limited duty setpoint generator that drives the 8-bit duty input of the fan/LED PWM stage.
- Accepts target duty values over a valid/ready handshake.
- Moves its output toward the target in fixed steps, paced by a PWM-period tick strobe, so the PWM never sees abrupt duty jumps.
- Holds one pending target while a ramp is in progress.

Parameters:
- STEP, 1: duty increment/decrement per step (1..255).
- TICKS_PER_STEP, 4: tick strobes between steps (1..65535); counter is 16 bits.
- DUTY_INIT, 0: duty value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tick  in  1  one-cycle strobe, one per PWM period
- tgt_valid  in  1  target offered
- tgt_duty  in  8  target duty, 0–255
- tgt_ready  out  1  target can be accepted this cycle
- duty  out  8  current duty, registered, feeds PWM
- busy  out  1  ramp in progress (state UP or DOWN)
- done  out  1  one-cycle pulse when duty reaches the active target

Interface: reset rst, synchronous, active-high; clock clk.

Behaviour:
- Reset values: duty=DUTY_INIT, state=IDLE, pending empty, tick counter=0, busy=0, done=0, tgt_ready=1.
- Handshake: transfer occurs on the rising edge where tgt_valid && tgt_ready. tgt_ready is 1 while the pending slot is empty; it is combinational from the pending flag only, never from tgt_valid.
- States:
  - IDLE: on transfer, load the active target. If target > duty, go to UP; if target < duty, go to DOWN; if equal, stay IDLE and pulse done on the next cycle. The tick counter clears on load.
  - UP/DOWN: a transfer writes the pending slot (pending full, so tgt_ready=0 next cycle). Each tick increments the counter. When the counter reaches TICKS_PER_STEP-1 and tick=1, apply a step and clear the counter.
- Step arithmetic: computed at 9 bits, no wrap.
  - UP: if duty+STEP >= target, duty=target; else duty+=STEP.
  - DOWN: if duty < target+STEP (9-bit compare), duty=target; else duty-=STEP.
- Completion: on the edge where duty becomes the target, done pulses for one cycle after that edge.
  - If pending is empty: state goes to IDLE.
  - If pending is full: the pending target becomes active on the same edge, pending clears, the counter clears, and the next state is chosen as in IDLE. If the pending target equals the new duty, there is an additional done pulse one cycle later.
- A new transfer arriving on the same edge as completion-with-empty-pending is handled as an IDLE load on the next cycle (the FSM goes IDLE first, then loads).
- Ticks with no active ramp are ignored. tick while tgt_valid is high is independent of the handshake.
- Latency: with a continuous tick, the first step lands TICKS_PER_STEP cycles after the transfer edge.
- Reset mid-ramp: duty returns to DUTY_INIT immediately at the reset edge, and pending is discarded.
- busy=1 exactly when state is UP or DOWN.

Optional Feature:
- DUTY_RAMP_ESTOP_EN
  - Defined: adds input port estop (1 bit). While estop=1:
    - duty=0 on the next edge; state=IDLE; pending cleared; counter cleared.
    - tgt_ready=0; done is not pulsed.
    - On release, the block resumes in IDLE with duty=0.
  - Undefined: no estop port; logic absent.

Decomposition:
- Package duty_ramp_pkg:
  - DUTY_W=8, CNT_W=16.
  - state enum {IDLE, UP, DOWN}.
  - Step compute function (9-bit saturating toward target).
- Sub-module: step_timer, the tick counter with clear input and step_en output.

Test Plan (STEP=16 and TICKS_PER_STEP=1 unless noted; tick=1 every cycle):
- Reset, then idle 10 cycles -> duty=0, busy=0, tgt_ready=1, done never high.
- Target 250 from 0 -> duty sequence 16, 32, …, 240, 250 on consecutive cycles; one done pulse; busy falls with done.
- From 250, target 5 -> duty 234, 218, …, 26, 10, 5; clamps to 5 (no underflow); one done.
- STEP=1, TICKS_PER_STEP=4, tick every 3rd cycle, target 3 -> duty advances 1 per 12 cycles; done after 36 cycles.
- During ramp to 200, offer 100 and then 50 -> 100 accepted; tgt_ready=0 holds 50 off until the 200 done. The ramp then goes DOWN to 100, then 50 is accepted; two further done pulses.
- Target equal to current duty (0) -> done one cycle after transfer; busy stays 0.
- Assert rst mid-ramp at duty=96 -> duty=DUTY_INIT next edge, pending dropped.
- With DUTY_RAMP_ESTOP_EN defined: estop mid-ramp at duty=128 -> duty=0 next edge, tgt_ready=0 while estop is high.
